// File: rtl/ring_capture_ram.sv
// ring_capture_ram: pre/post-trigger ring buffer capture with streamed readout.
// Optional RING_CAPTURE_DECIMATE_EN adds decim: accept every (decim+1)-th sample.
module ring_capture_ram #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 10,
    parameter int PRE_SAMPLES = 256
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  arm,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  trigger,
`ifdef RING_CAPTURE_DECIMATE_EN
    input  logic [7:0]            decim,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PRE_LAST  = (ADDR_WIDTH + 1)'(PRE_SAMPLES - 1);
    localparam logic [ADDR_WIDTH:0] POST_LAST = (ADDR_WIDTH + 1)'(DEPTH - PRE_SAMPLES - 1);
    localparam logic [ADDR_WIDTH:0] RD_LAST   = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] RD_ALL    = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, READ} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   fill_cnt;
    logic [ADDR_WIDTH:0]   post_cnt;
    logic [ADDR_WIDTH:0]   rd_cnt;
    logic                  capturing;
    logic                  acc;
    logic                  rd_en;
    logic                  xfer;

    assign capturing = (state == PRE) || (state == WAIT) || (state == POST);
`ifdef RING_CAPTURE_DECIMATE_EN
    logic [7:0] decim_r;
    logic [7:0] dcnt;
    assign acc = capturing && in_valid && (dcnt == 8'd0);
`else
    assign acc = capturing && in_valid;
`endif
    // Fetch the next word whenever the output register is empty or draining.
    assign rd_en = (state == READ) && (rd_cnt != RD_ALL) && (!out_valid || out_ready);
    assign xfer = out_valid && out_ready;
    assign busy = state != IDLE;
    assign out_data = out_valid ? ram_q : '0;

    always_ff @(posedge clock) begin
        if (acc)
            ram[wr_ptr] <= in_data;
        if (rd_en)
            ram_q <= ram[rd_addr];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_addr   <= '0;
            fill_cnt  <= '0;
            post_cnt  <= '0;
            rd_cnt    <= '0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef RING_CAPTURE_DECIMATE_EN
            decim_r   <= 8'd0;
            dcnt      <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
`ifdef RING_CAPTURE_DECIMATE_EN
            if (capturing && in_valid)
                dcnt <= (dcnt == decim_r) ? 8'd0 : dcnt + 8'd1;
`endif
            if (acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) begin
                rd_addr   <= rd_addr + 1'b1;
                rd_cnt    <= rd_cnt + 1'b1;
                out_valid <= 1'b1;
                out_last  <= rd_cnt == RD_LAST;
            end else if (xfer) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            case (state)
                IDLE: if (arm) begin
                    state    <= PRE;
                    fill_cnt <= '0;
                    post_cnt <= '0;
                    rd_cnt   <= '0;
`ifdef RING_CAPTURE_DECIMATE_EN
                    decim_r  <= decim;
                    dcnt     <= 8'd0;
`endif
                end
                PRE: if (acc) begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == PRE_LAST)
                        state <= WAIT;
                end
                // Trigger sample is the first post sample; readout starts PRE_SAMPLES earlier.
                WAIT: if (acc && trigger) begin
                    rd_addr  <= wr_ptr - ADDR_WIDTH'(PRE_SAMPLES);
                    post_cnt <= (ADDR_WIDTH + 1)'(1);
                    state    <= (POST_LAST == '0) ? READ : POST;
                end
                POST: if (acc) begin
                    post_cnt <= post_cnt + 1'b1;
                    if (post_cnt == POST_LAST)
                        state <= READ;
                end
                READ: if (xfer && out_last) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
